// File: rtl/risc8_timer16.sv
`default_nettype none
// ============================================================================
//  Module      : risc8_timer16
//  Description : IO-mapped 8/16-bit timer/counter for a small RISC core.
//                Ten-bit prescaler with five clock-select divides, free-run
//                or clear-on-compare counting, overflow and compare flags,
//                level interrupt output. A 16-bit counter is reached over an
//                8-bit bus through a shared TEMP byte: a low-byte read
//                snapshots the high byte, and a high-byte write is staged
//                until the low-byte write commits the full word.
//
//  Ports       : clk    - single clock, all state updates on its rising edge
//                reset  - synchronous active-high reset
//                ren    - IO read strobe
//                wen    - IO write strobe
//                addr   - 7-bit IO address
//                wdata  - 8-bit IO write data
//                rdata  - 8-bit IO read data, registered, held between reads
//                valid  - one-cycle pulse marking rdata valid
//                irq    - interrupt request level
//
//  Register map (offset from BASE):
//                +0 TCNTL  +1 TCNTH  +2 OCRL  +3 OCRH  +4 TCCR  +5 TIFR
//
//  Revision    : 1.0 - initial release
// ============================================================================
module risc8_timer16 #(
  parameter logic [6:0] BASE  = 7'h4A,
  // Counter width; only 8 and 16 are meaningful.
  parameter int         WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ren,
  input  logic       wen,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       valid,
  output logic       irq
);

  localparam bit         C_IS16    = (WIDTH == 16);
  localparam logic [6:0] C_A_TCNTL = BASE;
  localparam logic [6:0] C_A_TCNTH = BASE + 7'd1;
  localparam logic [6:0] C_A_OCRL  = BASE + 7'd2;
  localparam logic [6:0] C_A_OCRH  = BASE + 7'd3;
  localparam logic [6:0] C_A_TCCR  = BASE + 7'd4;
  localparam logic [6:0] C_A_TIFR  = BASE + 7'd5;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] ocr_q,   ocr_d;
  logic [5:0]       tccr_q,  tccr_d;
  logic             tov_q,   tov_d;
  logic             ocf_q,   ocf_d;
  logic [7:0]       temp_q,  temp_d;
  logic [9:0]       presc_q, presc_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             valid_q, valid_d;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic hit_tcntl, hit_tcnth, hit_ocrl, hit_ocrh, hit_tccr, hit_tifr, hit_any;
  logic rd_any, rd_tcntl;
  logic wr_tcntl, wr_tcnth, wr_ocrl, wr_ocrh, wr_tccr, wr_tifr;

  assign hit_tcntl = (addr == C_A_TCNTL);
  assign hit_tcnth = (addr == C_A_TCNTH);
  assign hit_ocrl  = (addr == C_A_OCRL);
  assign hit_ocrh  = (addr == C_A_OCRH);
  assign hit_tccr  = (addr == C_A_TCCR);
  assign hit_tifr  = (addr == C_A_TIFR);
  assign hit_any   = hit_tcntl | hit_tcnth | hit_ocrl | hit_ocrh | hit_tccr | hit_tifr;

  assign rd_any    = ren & hit_any;
  assign rd_tcntl  = ren & hit_tcntl;
  assign wr_tcntl  = wen & hit_tcntl;
  assign wr_tcnth  = wen & hit_tcnth;
  assign wr_ocrl   = wen & hit_ocrl;
  assign wr_ocrh   = wen & hit_ocrh;
  assign wr_tccr   = wen & hit_tccr;
  assign wr_tifr   = wen & hit_tifr;

  // --------------------------------------------------------------------------
  // Zero-extended views so byte selects work for either width.
  // For WIDTH=8 the high bytes are constant zero.
  // --------------------------------------------------------------------------
  logic [15:0] cnt_ext;
  logic [15:0] ocr_ext;
  logic [15:0] wr_word;

  assign cnt_ext = 16'(cnt_q);
  assign ocr_ext = 16'(ocr_q);
  // Full-word write value: staged high byte plus the low byte on the bus.
  // temp_q never leaves zero in the 8-bit build, so this is just wdata there.
  assign wr_word = {temp_q, wdata};

  // --------------------------------------------------------------------------
  // Prescaler
  // --------------------------------------------------------------------------
  logic [2:0] cs;
  logic [9:0] presc_top;
  logic       running;
  logic       tick;

  assign cs = tccr_q[2:0];

  always_comb begin
    presc_top = 10'd0;
    running   = 1'b1;
    case (cs)
      3'd1:    presc_top = 10'd0;
      3'd2:    presc_top = 10'd7;
      3'd3:    presc_top = 10'd63;
      3'd4:    presc_top = 10'd255;
      3'd5:    presc_top = 10'd1023;
      default: running   = 1'b0;
    endcase
  end

  assign tick = running & (presc_q == presc_top);

  always_comb begin
    presc_d = presc_q + 10'd1;
    // A stopped prescaler parks at zero; starting it needs a TCCR write,
    // which clears it anyway, so the parked value is never observable.
    if (wr_tccr || !running || tick) begin
      presc_d = 10'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Counter, compare and flags
  // --------------------------------------------------------------------------
  logic ctc;
  logic tov_set, ocf_set;
  logic tov_clr, ocf_clr;

  assign ctc     = tccr_q[3];
  assign tov_clr = wr_tifr & wdata[0];
  assign ocf_clr = wr_tifr & wdata[1];

  always_comb begin
    cnt_d   = cnt_q;
    tov_set = 1'b0;
    ocf_set = 1'b0;
    if (wr_tcntl) begin
      // CPU write beats a coincident tick; that tick raises no flag.
      cnt_d = WIDTH'(wr_word);
    end else if (tick) begin
      if (ctc) begin
        if (cnt_q == ocr_q) begin
          cnt_d   = '0;
          ocf_set = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        cnt_d   = cnt_q + WIDTH'(1);
        ocf_set = (cnt_q == ocr_q);
        tov_set = (cnt_q == '1);
      end
    end
  end

  always_comb begin
    ocr_d = ocr_q;
    if (wr_ocrl) begin
      ocr_d = WIDTH'(wr_word);
    end
  end

  always_comb begin
    temp_d = temp_q;
    if (C_IS16) begin
      if (rd_tcntl) begin
        temp_d = cnt_ext[15:8];
      end else if (wr_tcnth || wr_ocrh) begin
        temp_d = wdata;
      end
    end
  end

  always_comb begin
    tccr_d = tccr_q;
    if (wr_tccr) begin
      tccr_d = wdata[5:0];
    end
  end

  // Set has priority over a coincident clear.
  assign tov_d = (tov_q & ~tov_clr) | tov_set;
  assign ocf_d = (ocf_q & ~ocf_clr) | ocf_set;

  // --------------------------------------------------------------------------
  // Read port
  // --------------------------------------------------------------------------
  always_comb begin
    rdata_d = rdata_q;
    valid_d = rd_any;
    if (rd_any) begin
      if (hit_tcntl) begin
        rdata_d = cnt_ext[7:0];
      end else if (hit_tcnth) begin
        rdata_d = temp_q;
      end else if (hit_ocrl) begin
        rdata_d = ocr_ext[7:0];
      end else if (hit_ocrh) begin
        rdata_d = ocr_ext[15:8];
      end else if (hit_tccr) begin
        rdata_d = {2'b00, tccr_q};
      end else begin
        rdata_d = {6'b000000, ocf_q, tov_q};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      ocr_q   <= '1;
      tccr_q  <= 6'd0;
      tov_q   <= 1'b0;
      ocf_q   <= 1'b0;
      temp_q  <= 8'd0;
      presc_q <= 10'd0;
      rdata_q <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ocr_q   <= ocr_d;
      tccr_q  <= tccr_d;
      tov_q   <= tov_d;
      ocf_q   <= ocf_d;
      temp_q  <= temp_d;
      presc_q <= presc_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  assign rdata = rdata_q;
  assign valid = valid_q;
  assign irq   = (tov_q & tccr_q[5]) | (ocf_q & tccr_q[4]);

endmodule
`default_nettype wire

// File: tb/tb_risc8_timer16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_risc8_timer16
//  Description : Bench for risc8_timer16. A 16-bit instance is tracked every
//                cycle by an arithmetic model of the register file; an 8-bit
//                instance on the same bus is pinned with literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_risc8_timer16;

  localparam logic [6:0] BASE    = 7'h4A;
  localparam logic [6:0] A_TCNTL = BASE;
  localparam logic [6:0] A_TCNTH = BASE + 7'd1;
  localparam logic [6:0] A_OCRL  = BASE + 7'd2;
  localparam logic [6:0] A_OCRH  = BASE + 7'd3;
  localparam logic [6:0] A_TCCR  = BASE + 7'd4;
  localparam logic [6:0] A_TIFR  = BASE + 7'd5;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       ren   = 1'b0;
  logic       wen   = 1'b0;
  logic [6:0] addr  = 7'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] rdata, rdata8;
  logic       valid, valid8, irq, irq8;

  int n_vec  = 0;
  int n_err  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  risc8_timer16 #(.BASE(BASE), .WIDTH(16)) dut (
    .clk(clk), .reset(reset), .ren(ren), .wen(wen), .addr(addr),
    .wdata(wdata), .rdata(rdata), .valid(valid), .irq(irq)
  );

  risc8_timer16 #(.BASE(BASE), .WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .ren(ren), .wen(wen), .addr(addr),
    .wdata(wdata), .rdata(rdata8), .valid(valid8), .irq(irq8)
  );

  // --------------------------------------------------------------------------
  // Reference model of the 16-bit instance, in plain integers.
  // The prescaler is a phase count of cycles since it was last cleared;
  // a tick happens whenever phase mod divide hits divide-1.
  // --------------------------------------------------------------------------
  int         m_cnt   = 0;
  int         m_ocr   = 65535;
  int         m_tccr  = 0;
  int         m_temp  = 0;
  int         m_phase = 0;
  bit         m_tov   = 1'b0;
  bit         m_ocf   = 1'b0;
  bit         m_valid = 1'b0;
  bit         m_irq   = 1'b0;
  logic [7:0] m_rdata = 8'd0;

  always @(posedge clk) begin
    int off, cs, div, n_cnt, n_ocr, n_temp, n_tccr, n_phase;
    bit hit, rd, wr, tk, ctc, s_tov, s_ocf, c_tov, c_ocf;
    if (reset) begin
      m_cnt = 0; m_ocr = 65535; m_tccr = 0; m_temp = 0; m_phase = 0;
      m_tov = 0; m_ocf = 0; m_rdata = 8'd0; m_valid = 0;
    end else begin
      off = int'(addr) - int'(BASE);
      hit = (off >= 0) && (off <= 5);
      rd  = ren && hit;
      wr  = wen && hit;
      cs  = m_tccr % 8;
      case (cs)
        1: div = 1;
        2: div = 8;
        3: div = 64;
        4: div = 256;
        5: div = 1024;
        default: div = 0;
      endcase
      tk  = (div != 0) && ((m_phase % div) == div - 1);
      ctc = ((m_tccr >> 3) % 2) == 1;
      n_cnt = m_cnt; n_ocr = m_ocr; n_temp = m_temp; n_tccr = m_tccr;
      n_phase = m_phase + 1;
      s_tov = 0; s_ocf = 0; c_tov = 0; c_ocf = 0;

      m_valid = rd;
      if (rd) begin
        case (off)
          0: begin m_rdata = 8'(m_cnt % 256); n_temp = m_cnt / 256; end
          1: m_rdata = 8'(m_temp);
          2: m_rdata = 8'(m_ocr % 256);
          3: m_rdata = 8'(m_ocr / 256);
          4: m_rdata = 8'(m_tccr);
          default: m_rdata = 8'(int'(m_ocf) * 2 + int'(m_tov));
        endcase
      end

      if (wr) begin
        case (off)
          0: n_cnt  = m_temp * 256 + int'(wdata);
          1: n_temp = int'(wdata);
          2: n_ocr  = m_temp * 256 + int'(wdata);
          3: n_temp = int'(wdata);
          4: begin n_tccr = int'(wdata) % 64; n_phase = 0; end
          default: begin c_tov = wdata[0]; c_ocf = wdata[1]; end
        endcase
      end

      if (tk && !(wr && off == 0)) begin
        if (ctc && m_cnt == m_ocr) begin
          n_cnt = 0;
          s_ocf = 1;
        end else begin
          n_cnt = (m_cnt + 1) % 65536;
          if (!ctc) begin
            s_ocf = (m_cnt == m_ocr);
            s_tov = (m_cnt == 65535);
          end
        end
      end

      m_tov   = (m_tov && !c_tov) || s_tov;
      m_ocf   = (m_ocf && !c_ocf) || s_ocf;
      m_cnt   = n_cnt;
      m_ocr   = n_ocr;
      m_temp  = n_temp;
      m_tccr  = n_tccr;
      m_phase = n_phase;
    end
    m_irq = (m_tov && ((m_tccr >> 5) % 2) == 1) || (m_ocf && ((m_tccr >> 4) % 2) == 1);
  end

  // --------------------------------------------------------------------------
  // Cycle-by-cycle compare against the model
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (rdata !== m_rdata || valid !== m_valid || irq !== m_irq) begin
        n_err++;
        $display("FAIL model t=%0t: rdata=%02h valid=%b irq=%b, expected rdata=%02h valid=%b irq=%b",
                 $time, rdata, valid, irq, m_rdata, m_valid, m_irq);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [6:0] a, input logic [7:0] d);
    ren = 1'b0; wen = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [6:0] a, output logic [7:0] d);
    wen = 1'b0; ren = 1'b1; addr = a;
    @(negedge clk);
    ren = 1'b0;
    d = rdata;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [7:0] d;

    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check8("rst_rdata", rdata, 8'h00);
    check8("rst_valid", {7'd0, valid}, 8'h00);
    check8("rst_irq",   {7'd0, irq},   8'h00);
    bus_rd(A_TCNTL, d); check8("rst_tcntl", d, 8'h00);
    check8("rd_valid_pulse", {7'd0, valid}, 8'h01);
    bus_rd(A_OCRH, d);  check8("rst_ocrh", d, 8'hFF);
    bus_rd(A_TCCR, d);  check8("rst_tccr", d, 8'h00);

    // Free run at /1 for 300 cycles, then snapshot
    bus_wr(A_TCCR, 8'h01);
    repeat (300) @(negedge clk);
    bus_rd(A_TCNTL, d); check8("run300_lo", d, 8'h2C);
    bus_rd(A_TCNTH, d); check8("run300_hi", d, 8'h01);
    bus_rd(A_TIFR, d);  check8("run300_tifr", d, 8'h00);

    // Preset near the top: overflow on the second tick (OCR=FFFF matches too)
    bus_wr(A_TCNTH, 8'hFF);
    bus_wr(A_TCNTL, 8'hFE);
    repeat (2) @(negedge clk);
    bus_rd(A_TIFR, d);  check8("ovf_tifr", d, 8'h03);
    bus_rd(A_TCNTL, d); check8("ovf_wrapped", d, 8'h01);
    bus_wr(A_TIFR, 8'h03);
    bus_wr(A_TCCR, 8'h00);

    // CTC at /8 with OCR=9, OCIE on: OCF every 80 cycles
    bus_wr(A_TCNTH, 8'h00);
    bus_wr(A_TCNTL, 8'h00);
    bus_wr(A_OCRH, 8'h00);
    bus_wr(A_OCRL, 8'h09);
    bus_wr(A_TCCR, 8'h1A);
    repeat (79) @(negedge clk);
    bus_rd(A_TIFR, d);  check8("ctc_before", d, 8'h00);
    bus_rd(A_TIFR, d);  check8("ctc_ocf", d, 8'h02);
    bus_wr(A_TIFR, 8'h02);
    repeat (77) @(negedge clk);
    bus_wr(A_TIFR, 8'h02);             // lands on the edge OCF sets again
    bus_rd(A_TIFR, d);  check8("set_beats_clr", d, 8'h02);
    check8("ocie_irq", {7'd0, irq}, 8'h01);
    bus_wr(A_TIFR, 8'h02);
    check8("clr_irq", {7'd0, irq}, 8'h00);
    bus_wr(A_TCCR, 8'h00);

    // Consistent 16-bit snapshot across a byte carry
    bus_wr(A_TCNTH, 8'h12);
    bus_wr(A_TCNTL, 8'hFF);
    bus_wr(A_TCCR, 8'h01);
    bus_rd(A_TCNTL, d); check8("snap_lo", d, 8'hFF);
    bus_rd(A_TCNTH, d); check8("snap_hi", d, 8'h12);

    // Reset over a running counter with flags up and bus traffic
    bus_wr(A_TCCR, 8'h00);
    bus_wr(A_TCNTH, 8'h00);
    bus_wr(A_TCNTL, 8'h05);
    bus_wr(A_TCCR, 8'h31);
    repeat (10) @(negedge clk);
    check8("pre_rst_irq", {7'd0, irq}, 8'h01);
    reset = 1'b1; ren = 1'b1; wen = 1'b1; addr = A_TCCR; wdata = 8'h3F;
    @(negedge clk);
    reset = 1'b0; ren = 1'b0; wen = 1'b0;
    check8("mid_rst_rdata", rdata, 8'h00);
    check8("mid_rst_valid", {7'd0, valid}, 8'h00);
    check8("mid_rst_irq",   {7'd0, irq},   8'h00);
    bus_rd(A_OCRL, d);  check8("mid_rst_ocrl", d, 8'hFF);
    bus_rd(A_TCCR, d);  check8("mid_rst_tccr", d, 8'h00);

    // 8-bit instance
    bus_wr(A_TCNTH, 8'hAA);
    bus_rd(A_TCNTH, d);
    check8("w8_tcnth", rdata8, 8'h00);
    check8("w8_valid", {7'd0, valid8}, 8'h01);
    bus_wr(A_TCNTL, 8'hFE);
    bus_wr(A_TCCR, 8'h21);
    @(negedge clk);
    check8("w8_irq_before", {7'd0, irq8}, 8'h00);
    @(negedge clk);
    check8("w8_irq_wrap", {7'd0, irq8}, 8'h01);
    bus_rd(A_TCNTL, d);
    check8("w8_wrapped", rdata8, 8'h00);
    bus_rd(A_OCRH, d);
    check8("w8_ocrh", rdata8, 8'h00);

    // Randomized traffic, model-checked
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      int op;
      op    = $urandom_range(0, 99);
      ren   = 1'b0;
      wen   = 1'b0;
      reset = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 9) == 0) addr = 7'($urandom_range(0, 127));
      else                           addr = BASE + 7'($urandom_range(0, 5));
      wdata = 8'($urandom);
      if (op < 25) begin
        ren = 1'b1;
      end else if (op < 45) begin
        wen = 1'b1;
        if (addr == A_TCCR && $urandom_range(0, 4) != 0) wdata[2:0] = 3'($urandom_range(1, 3));
        if (addr == A_TCNTH && $urandom_range(0, 1) == 0) wdata = 8'hFF;
        if (addr == A_OCRH && $urandom_range(0, 1) == 0) wdata = 8'h00;
      end
      @(negedge clk);
    end
    reset = 1'b0; ren = 1'b0; wen = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
